// File: rtl/mcp23s17_spi_responder.sv
// rtl/mcp23s17_spi_responder.sv - MCP23S17-compatible SPI mode-0 I/O expander responder
//
// Emulates the bank-0 register map of an MCP23S17 behind an SPI mode-0 slave.
// Ports:
//   clk, rst_n               system clock, synchronous active-low reset
//   cs, sck, mosi, miso      SPI link (cs active low, inputs asynchronous to clk)
//   gpio_a_in, gpio_b_in     pin levels of port A/B (asynchronous)
//   gpio_a_out, gpio_b_out   output latches OLATA/OLATB
//   gpio_a_oe, gpio_b_oe     output enables (~IODIRA/~IODIRB)
//   inta, intb               interrupt outputs, active level = IOCON.INTPOL
module mcp23s17_spi_responder #(
    parameter logic [2:0] HW_ADDR = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] gpio_a_in,
    input  logic [7:0] gpio_b_in,
    output logic [7:0] gpio_a_out,
    output logic [7:0] gpio_b_out,
    output logic [7:0] gpio_a_oe,
    output logic [7:0] gpio_b_oe,
    output logic       inta,
    output logic       intb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_DATA,
        S_ABORT
    } state_t;

    state_t state_q, state_d;

    // Synchronizers. cs resets to the asserted level so that a cs held low
    // across reset is never mistaken for a fresh falling edge.
    logic [1:0] cs_sync, sck_sync, mosi_sync;
    logic       cs_prev, sck_prev;
    logic [7:0] ga_meta, ga_s, ga_prev;
    logic [7:0] gb_meta, gb_s, gb_prev;
    logic       cs_s, sck_s, mosi_s;
    logic       cs_fall, sck_rise, sck_fall;

    // Frame datapath
    logic [2:0] bit_cnt;
    logic [6:0] sh_in;
    logic [7:0] rx_byte;
    logic [7:0] ptr, ptr_next;
    logic       rd;
    logic [6:0] tx_sh;
    logic       miso_q;
    logic       byte_done, opcode_ok, rd_active, tx_load, tx_shift, wr_en;
    logic [7:0] rdata;

    // Register file
    logic [7:0] iodir_a, iodir_b, ipol_a, ipol_b, gpinten_a, gpinten_b;
    logic [7:0] defval_a, defval_b, intcon_a, intcon_b, gppu_a, gppu_b;
    logic [7:0] olat_a, olat_b, intf_a, intf_b, intcap_a, intcap_b;
    logic [6:0] iocon;
    logic       mirror, seqop, haen, intpol;

    // Interrupt logic
    logic [7:0] ev_a, ev_b;
    logic       clr_a, clr_b, act_a, act_b, lvl_a, lvl_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync   <= 2'b00;
            cs_prev   <= 1'b0;
            sck_sync  <= 2'b00;
            sck_prev  <= 1'b0;
            mosi_sync <= 2'b00;
            ga_meta   <= 8'h00;
            ga_s      <= 8'h00;
            ga_prev   <= 8'h00;
            gb_meta   <= 8'h00;
            gb_s      <= 8'h00;
            gb_prev   <= 8'h00;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            cs_prev   <= cs_sync[1];
            sck_sync  <= {sck_sync[0], sck};
            sck_prev  <= sck_sync[1];
            mosi_sync <= {mosi_sync[0], mosi};
            ga_meta   <= gpio_a_in;
            ga_s      <= ga_meta;
            ga_prev   <= ga_s;
            gb_meta   <= gpio_b_in;
            gb_s      <= gb_meta;
            gb_prev   <= gb_s;
        end
    end

    assign cs_s     = cs_sync[1];
    assign sck_s    = sck_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = sck_prev & ~sck_s;

    assign mirror = iocon[6];
    assign seqop  = iocon[5];
    assign haen   = iocon[3];
    assign intpol = iocon[1];

    assign rx_byte   = {sh_in, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && !cs_s;
    assign opcode_ok = (rx_byte[7:4] == 4'b0100) && (!haen || (rx_byte[3:1] == HW_ADDR));
    assign rd_active = (state_q == S_DATA) && rd;
    assign tx_load   = rd_active && sck_fall && (bit_cnt == 3'd0);
    assign tx_shift  = rd_active && sck_fall;
    assign wr_en     = (state_q == S_DATA) && !rd && byte_done;
    assign ptr_next  = seqop ? ptr : ((ptr == 8'h15) ? 8'h00 : ptr + 8'h01);

    // Loading GPIOx or INTCAPx into the read shifter acknowledges that port.
    assign clr_a = tx_load && ((ptr == 8'h10) || (ptr == 8'h12));
    assign clr_b = tx_load && ((ptr == 8'h11) || (ptr == 8'h13));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An IDLE that sees cs low without a falling edge (e.g. reset mid-frame)
    // parks in ABORT until cs is released.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) state_d = S_OPCODE;
                else if (!cs_s) state_d = S_ABORT;
            end
            S_OPCODE: begin
                if (cs_s) state_d = S_IDLE;
                else if (byte_done) state_d = opcode_ok ? S_ADDR : S_ABORT;
            end
            S_ADDR: begin
                if (cs_s) state_d = S_IDLE;
                else if (byte_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (cs_s) state_d = S_IDLE;
            end
            S_ABORT: begin
                if (cs_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            sh_in   <= 7'h00;
            ptr     <= 8'h00;
            rd      <= 1'b0;
            tx_sh   <= 7'h00;
            miso_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE || state_q == S_ABORT) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh_in   <= rx_byte[6:0];
            end
            if (byte_done) begin
                case (state_q)
                    S_OPCODE: rd  <= rx_byte[0];
                    S_ADDR:   ptr <= rx_byte;
                    S_DATA:   ptr <= ptr_next;
                    default:  ;
                endcase
            end
            if (tx_load) begin
                miso_q <= rdata[7];
                tx_sh  <= rdata[6:0];
            end else if (tx_shift) begin
                miso_q <= tx_sh[6];
                tx_sh  <= {tx_sh[5:0], 1'b0};
            end else if (!rd_active) begin
                miso_q <= 1'b0;
            end
        end
    end

    assign miso = miso_q & rd_active;

    always_comb begin
        rdata = 8'h00;
        case (ptr)
            8'h00:   rdata = iodir_a;
            8'h01:   rdata = iodir_b;
            8'h02:   rdata = ipol_a;
            8'h03:   rdata = ipol_b;
            8'h04:   rdata = gpinten_a;
            8'h05:   rdata = gpinten_b;
            8'h06:   rdata = defval_a;
            8'h07:   rdata = defval_b;
            8'h08:   rdata = intcon_a;
            8'h09:   rdata = intcon_b;
            8'h0A,
            8'h0B:   rdata = {1'b0, iocon};
            8'h0C:   rdata = gppu_a;
            8'h0D:   rdata = gppu_b;
            8'h0E:   rdata = intf_a;
            8'h0F:   rdata = intf_b;
            8'h10:   rdata = intcap_a;
            8'h11:   rdata = intcap_b;
            8'h12:   rdata = ga_s ^ ipol_a;
            8'h13:   rdata = gb_s ^ ipol_b;
            8'h14:   rdata = olat_a;
            8'h15:   rdata = olat_b;
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iodir_a   <= 8'hFF;
            iodir_b   <= 8'hFF;
            ipol_a    <= 8'h00;
            ipol_b    <= 8'h00;
            gpinten_a <= 8'h00;
            gpinten_b <= 8'h00;
            defval_a  <= 8'h00;
            defval_b  <= 8'h00;
            intcon_a  <= 8'h00;
            intcon_b  <= 8'h00;
            iocon     <= 7'h00;
            gppu_a    <= 8'h00;
            gppu_b    <= 8'h00;
            olat_a    <= 8'h00;
            olat_b    <= 8'h00;
        end else if (wr_en) begin
            case (ptr)
                8'h00:        iodir_a   <= rx_byte;
                8'h01:        iodir_b   <= rx_byte;
                8'h02:        ipol_a    <= rx_byte;
                8'h03:        ipol_b    <= rx_byte;
                8'h04:        gpinten_a <= rx_byte;
                8'h05:        gpinten_b <= rx_byte;
                8'h06:        defval_a  <= rx_byte;
                8'h07:        defval_b  <= rx_byte;
                8'h08:        intcon_a  <= rx_byte;
                8'h09:        intcon_b  <= rx_byte;
                8'h0A, 8'h0B: iocon     <= rx_byte[6:0];
                8'h0C:        gppu_a    <= rx_byte;
                8'h0D:        gppu_b    <= rx_byte;
                8'h12, 8'h14: olat_a    <= rx_byte;
                8'h13, 8'h15: olat_b    <= rx_byte;
                default:      ;
            endcase
        end
    end

    assign gpio_a_out = olat_a;
    assign gpio_b_out = olat_b;
    assign gpio_a_oe  = ~iodir_a;
    assign gpio_b_oe  = ~iodir_b;

    // INTCON=1 compares against DEFVAL (level), INTCON=0 against the previous sample (edge).
    assign ev_a = gpinten_a & ((intcon_a & (ga_s ^ defval_a)) | (~intcon_a & (ga_s ^ ga_prev)));
    assign ev_b = gpinten_b & ((intcon_b & (gb_s ^ defval_b)) | (~intcon_b & (gb_s ^ gb_prev)));

    // A clear and a new event in the same cycle resolve in favour of the event,
    // which also re-arms the capture since the flags are being emptied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intf_a   <= 8'h00;
            intf_b   <= 8'h00;
            intcap_a <= 8'h00;
            intcap_b <= 8'h00;
        end else begin
            intf_a <= (clr_a ? 8'h00 : intf_a) | ev_a;
            intf_b <= (clr_b ? 8'h00 : intf_b) | ev_b;
            if ((|ev_a) && (clr_a || (intf_a == 8'h00))) intcap_a <= ga_s;
            if ((|ev_b) && (clr_b || (intf_b == 8'h00))) intcap_b <= gb_s;
        end
    end

    assign act_a = |intf_a;
    assign act_b = |intf_b;
    assign lvl_a = mirror ? (act_a | act_b) : act_a;
    assign lvl_b = mirror ? (act_a | act_b) : act_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inta <= 1'b1;
            intb <= 1'b1;
        end else begin
            inta <= lvl_a ? intpol : ~intpol;
            intb <= lvl_b ? intpol : ~intpol;
        end
    end

endmodule

// File: tb/tb_mcp23s17_spi_responder.sv
// tb/tb_mcp23s17_spi_responder.sv - scoreboard bench for mcp23s17_spi_responder
module tb_mcp23s17_spi_responder;

    localparam int HALF = 4;
    localparam int SIG_INTA = 0, SIG_INTB = 1, SIG_A_OE = 2, SIG_A_OUT = 3;
    localparam int SIG_B_OE = 4, SIG_B_OUT = 5, SIG_MISO = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] gpio_a_in = 8'h00;
    logic [7:0] gpio_b_in = 8'h00;
    logic [7:0] gpio_a_out, gpio_b_out, gpio_a_oe, gpio_b_oe;
    logic       inta, intb;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [7:0] want;
    } byte_exp_t;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] want;
    } lvl_exp_t;

    byte_exp_t bq[$];
    lvl_exp_t  lq[$];

    always #5 clk = ~clk;

    mcp23s17_spi_responder #(.HW_ADDR(3'b000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .gpio_a_in  (gpio_a_in),
        .gpio_b_in  (gpio_b_in),
        .gpio_a_out (gpio_a_out),
        .gpio_b_out (gpio_b_out),
        .gpio_a_oe  (gpio_a_oe),
        .gpio_b_oe  (gpio_b_oe),
        .inta       (inta),
        .intb       (intb)
    );

    function automatic logic [7:0] sig_val(input int id);
        case (id)
            SIG_INTA:  return {7'b0, inta};
            SIG_INTB:  return {7'b0, intb};
            SIG_A_OE:  return gpio_a_oe;
            SIG_A_OUT: return gpio_a_out;
            SIG_B_OE:  return gpio_b_oe;
            SIG_B_OUT: return gpio_b_out;
            SIG_MISO:  return {7'b0, miso};
            default:   return 8'hxx;
        endcase
    endfunction

    // Byte monitor: reassembles miso as a master would (sampled on sck rise)
    // and checks every completed byte against the scoreboard.
    initial begin : byte_mon
        int         nb;
        logic [7:0] acc;
        byte_exp_t  e;
        nb = 0;
        acc = 8'h00;
        forever begin
            @(posedge sck or negedge cs);
            if (!cs && !sck) begin
                nb = 0;
            end else if (!cs && sck) begin
                acc = {acc[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    n_cmp++;
                    if (bq.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_byte: miso %02h, none expected", acc);
                    end else begin
                        e = bq.pop_front();
                        if (acc !== e.want) begin
                            n_bad++;
                            $display("FAIL %s: miso byte %02h, expected %02h", e.name, acc, e.want);
                        end
                    end
                end
            end
        end
    end

    // Level monitor: compares static outputs whenever a check is queued.
    initial begin : lvl_mon
        lvl_exp_t   e;
        logic [7:0] act;
        forever begin
            wait (lq.size() > 0);
            e = lq.pop_front();
            act = sig_val(e.sig);
            n_cmp++;
            if (act !== e.want) begin
                n_bad++;
                $display("FAIL %s: got %02h, expected %02h", e.name, act, e.want);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int sig, input logic [7:0] want);
        lq.push_back('{name: nm, sig: sig, want: want});
        #1;
    endtask

    task automatic shift_bits(input int nbits, input logic [31:0] data);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[31 - i];
            clks(HALF);
            sck = 1'b1;
            clks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic expect_bytes(input string nm, input int nbytes, input logic [31:0] rx);
        for (int i = 0; i < nbytes; i++)
            bq.push_back('{name: $sformatf("%s[%0d]", nm, i), want: rx[31 - 8*i -: 8]});
    endtask

    // tx/rx are packed MSB-first: byte 0 in [31:24].
    task automatic frame(input string nm, input int nbytes, input logic [31:0] tx, input logic [31:0] rx);
        expect_bytes(nm, nbytes, rx);
        cs = 1'b0;
        clks(HALF);
        shift_bits(8 * nbytes, tx);
        clks(HALF);
        cs = 1'b1;
        clks(HALF);
    endtask

    initial begin : stim
        clks(3);
        rst_n = 1'b1;
        clks(6);
        chk("rst_inta", SIG_INTA, 8'h01);
        chk("rst_intb", SIG_INTB, 8'h01);
        chk("rst_a_oe", SIG_A_OE, 8'h00);
        chk("rst_a_out", SIG_A_OUT, 8'h00);
        chk("rst_b_oe", SIG_B_OE, 8'h00);
        chk("rst_miso", SIG_MISO, 8'h00);

        // Configuration
        frame("wr_iocon", 3, 32'h400A5200, 32'h0);
        frame("wr_iodira", 3, 32'h4000FF00, 32'h0);
        chk("cfg_inta", SIG_INTA, 8'h00);
        chk("cfg_intb", SIG_INTB, 8'h00);
        chk("cfg_a_oe", SIG_A_OE, 8'h00);
        frame("wr_iodirb", 3, 32'h40010F00, 32'h0);
        chk("iodirb_oe", SIG_B_OE, 8'hF0);
        frame("wr_gpioa", 3, 32'h4012C300, 32'h0);
        chk("olata_via_gpio", SIG_A_OUT, 8'hC3);

        // GPIO reads, input polarity
        gpio_a_in = 8'hA5;
        clks(4);
        frame("rd_gpioa", 3, 32'h41120000, 32'h0000A500);
        frame("wr_ipola", 3, 32'h40020F00, 32'h0);
        frame("rd_gpioa_ipol", 3, 32'h41120000, 32'h0000AA00);
        gpio_b_in = 8'h3C;
        clks(4);
        frame("seq_rd", 4, 32'h41120000, 32'h0000AA3C);

        // SEQOP and IOCON read-back (BANK bit reads 0)
        frame("wr_iocon_seq", 3, 32'h400A7200, 32'h0);
        frame("seqop_rd", 4, 32'h41120000, 32'h0000AAAA);
        frame("rd_iocon_seq", 3, 32'h410A0000, 32'h00007200);
        frame("wr_iocon_bank", 3, 32'h400AD200, 32'h0);
        frame("rd_iocon_bank", 3, 32'h410A0000, 32'h00005200);

        // Pointer wrap and out-of-map locations
        frame("wr_olatb", 3, 32'h40155A00, 32'h0);
        chk("olatb_out", SIG_B_OUT, 8'h5A);
        frame("wrap_rd", 4, 32'h41150000, 32'h00005AFF);
        frame("wr_hole", 3, 32'h40207700, 32'h0);
        frame("rd_hole", 3, 32'h41200000, 32'h0);

        // Interrupts: edge mode on port A, mirrored, active high
        frame("wr_ipola0", 3, 32'h40020000, 32'h0);
        frame("wr_gpintena", 3, 32'h4004FF00, 32'h0);
        chk("int_idle_a", SIG_INTA, 8'h00);
        chk("int_idle_b", SIG_INTB, 8'h00);
        gpio_a_in = 8'hAD;
        clks(4);
        chk("int_lat_a", SIG_INTA, 8'h01);
        chk("int_lat_b", SIG_INTB, 8'h01);
        frame("rd_intfa", 3, 32'h410E0000, 32'h00000800);
        chk("intf_rd_keeps", SIG_INTA, 8'h01);
        frame("rd_intcapa", 3, 32'h41100000, 32'h0000AD00);
        chk("clr_inta", SIG_INTA, 8'h00);
        chk("clr_intb", SIG_INTB, 8'h00);

        // Toggle while a clearing GPIO read is in flight
        expect_bytes("rd_gpioa_tog", 3, 32'h0000AD00);
        cs = 1'b0;
        clks(HALF);
        shift_bits(20, 32'h41120000);
        gpio_a_in = 8'hA5;
        shift_bits(4, 32'h0);
        clks(HALF);
        cs = 1'b1;
        clks(HALF);
        chk("tog_inta", SIG_INTA, 8'h01);
        chk("tog_intb", SIG_INTB, 8'h01);
        frame("rd_intcapa2", 3, 32'h41100000, 32'h0000A500);
        chk("clr2_inta", SIG_INTA, 8'h00);

        // Hardware address check
        frame("wr_haen", 3, 32'h400A5A00, 32'h0);
        frame("rd_badaddr", 3, 32'h43000000, 32'h0);
        frame("wr_badaddr", 3, 32'h42000000, 32'h0);
        chk("badaddr_oe", SIG_A_OE, 8'h00);
        frame("rd_goodaddr", 3, 32'h410A0000, 32'h00005A00);

        // Partial data byte is discarded
        expect_bytes("partial", 2, 32'h0);
        cs = 1'b0;
        clks(HALF);
        shift_bits(16, 32'h40140000);
        shift_bits(5, 32'h0F000000);
        clks(HALF);
        cs = 1'b1;
        clks(HALF);
        chk("partial_olata", SIG_A_OUT, 8'hC3);

        // Reset mid-write with cs held low; bits after reset must be ignored
        expect_bytes("rst_frame", 4, 32'h0);
        expect_bytes("rst_frame_tail", 1, 32'h0);
        cs = 1'b0;
        clks(HALF);
        shift_bits(20, 32'h4014F000);
        rst_n = 1'b0;
        clks(1);
        rst_n = 1'b1;
        shift_bits(24, 32'h4014FF00);
        clks(HALF);
        chk("rst_abort_olata", SIG_A_OUT, 8'h00);
        cs = 1'b1;
        clks(HALF);
        chk("rst2_a_out", SIG_A_OUT, 8'h00);
        chk("rst2_b_out", SIG_B_OUT, 8'h00);
        chk("rst2_b_oe", SIG_B_OE, 8'h00);
        chk("rst2_inta", SIG_INTA, 8'h01);
        chk("rst2_intb", SIG_INTB, 8'h01);
        chk("rst2_miso", SIG_MISO, 8'h00);
        frame("post_rst_wr", 3, 32'h40145500, 32'h0);
        chk("post_rst_olata", SIG_A_OUT, 8'h55);
        frame("post_rst_rd", 3, 32'h41140000, 32'h00005500);

        clks(4);
        n_cmp++;
        if (bq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d bytes left, expected 0", bq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
